// File: rtl/irq_pending_latch.sv
// Request-capture stage ahead of the 16-input priority encoder: synchronises irq lines,
// latches rising edges as pending bits and runs a req/ack handshake that clears one bit.
module irq_pending_latch #(
   parameter  int unsigned N_SRC       = 16,
   parameter  int unsigned SYNC_STAGES = 2,
   localparam int unsigned ID_W        = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_in,
   input  logic [N_SRC-1:0] mask,
   input  logic             ack,
   input  logic [ID_W-1:0]  ack_id,
   input  logic             ovr_clr,
   output logic [N_SRC-1:0] pend_vec,
   output logic             enc_enable,
   output logic             irq_req,
   output logic             ack_err,
   output logic [N_SRC-1:0] overrun
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
   logic [N_SRC-1:0] hist_q;
   logic [N_SRC-1:0] pending_q;

   logic [N_SRC-1:0] rise_c;
   logic             ack_take_c;
   logic             ack_hit_c;
   logic [N_SRC-1:0] clr_vec_c;
   logic [N_SRC-1:0] pending_d;
   logic [N_SRC-1:0] overrun_d;

   // Synchroniser chain plus one history stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge detect, ack qualification, pending/overrun next values (set beats clear)
   always_comb begin
      rise_c     = sync_q[SYNC_STAGES-1] & ~hist_q;
      ack_take_c = ack && (state_q == S_REQ);
      ack_hit_c  = pend_vec[ack_id];
      clr_vec_c  = '0;
      if (ack_take_c && ack_hit_c) begin
         clr_vec_c = N_SRC'(1) << ack_id;
      end
      pending_d = (pending_q & ~clr_vec_c) | rise_c;
      overrun_d = (ovr_clr ? '0 : overrun) | (rise_c & pending_q);
   end

   // Handshake sequencing; HOLD gives pend_vec and the encoder a cycle to settle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pend_vec != '0) state_d = S_REQ;
         S_REQ:   if (ack) state_d = S_HOLD;
         S_HOLD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         pend_vec   <= '0;
         overrun    <= '0;
         irq_req    <= 1'b0;
         enc_enable <= 1'b0;
         ack_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         pend_vec   <= pending_q & ~mask;
         overrun    <= overrun_d;
         irq_req    <= (state_d == S_REQ);
         enc_enable <= (state_d == S_REQ);
         ack_err    <= ack_take_c && !ack_hit_c;
      end
   end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed handshake scenarios plus random traffic, scored
// per cycle against a delay-line / request-phase reference model.
module tb_irq_pending_latch;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] irq_in;
   logic [15:0] mask;
   logic        ack;
   logic [3:0]  ack_id;
   logic        ovr_clr;
   logic [15:0] pend_vec;
   logic        enc_enable;
   logic        irq_req;
   logic        ack_err;
   logic [15:0] overrun;

   irq_pending_latch #(.N_SRC(16), .SYNC_STAGES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .mask       (mask),
      .ack        (ack),
      .ack_id     (ack_id),
      .ovr_clr    (ovr_clr),
      .pend_vec   (pend_vec),
      .enc_enable (enc_enable),
      .irq_req    (irq_req),
      .ack_err    (ack_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pv;
      logic        req;
      logic        aerr;
      logic [15:0] ovr;
   } obs_t;

   obs_t want_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: samples[k] is irq_in as captured k+1 edges ago
   logic [15:0] samples[$];
   logic [15:0] m_pend, m_ovr, m_pv;
   bit          m_req, m_aerr;
   int          m_gap;

   task automatic model_reset();
      samples.delete();
      for (int k = 0; k <= S; k++) samples.push_back(16'h0);
      m_pend = '0; m_ovr = '0; m_pv = '0;
      m_req = 0; m_aerr = 0; m_gap = 0;
   endtask

   task automatic model_edge();
      logic [15:0] rise, clr, new_pv;
      bit took, hit;
      rise   = samples[S-1] & ~samples[S];
      took   = ack && m_req;
      hit    = m_pv[ack_id];
      clr    = (took && hit) ? (16'(1) << ack_id) : 16'h0;
      new_pv = m_pend & ~mask;
      m_ovr  = (ovr_clr ? 16'h0 : m_ovr) | (rise & m_pend);
      m_pend = (m_pend & ~clr) | rise;
      m_aerr = took && !hit;
      if (m_req) begin
         if (ack) begin m_req = 0; m_gap = 1; end
      end else if (m_gap > 0) begin
         m_gap = m_gap - 1;
      end else if (m_pv != 16'h0) begin
         m_req = 1;
      end
      m_pv = new_pv;
      samples.push_front(irq_in);
      void'(samples.pop_back());
   endtask

   initial model_reset();

   always @(negedge rst_n) begin
      model_reset();
      want_q.delete();
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
         want_q.push_back('0);
      end else begin
         model_edge();
         want_q.push_back('{pv: m_pv, req: m_req, aerr: m_aerr, ovr: m_ovr});
      end
   end

   // Monitor: compare every presented cycle of DUT outputs against the queued prediction
   always @(negedge clk) begin
      obs_t w, got;
      if (want_q.size() > 0) begin
         w   = want_q.pop_front();
         got = '{pv: pend_vec, req: irq_req, aerr: ack_err, ovr: overrun};
         checks++;
         if (got !== w || enc_enable !== w.req) begin
            errors++;
            $display("FAIL cycle t=%0t pend_vec=%h/%h irq_req=%b/%b enc_enable=%b ack_err=%b/%b overrun=%h/%h",
                     $time, got.pv, w.pv, got.req, w.req, enc_enable, got.aerr, w.aerr, got.ovr, w.ovr);
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(string nm, logic [31:0] got, logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, got, req, $time);
      end
   endtask

   task automatic do_ack(logic [3:0] id);
      ack = 1'b1;
      ack_id = id;
      step();
      ack = 1'b0;
   endtask

   task automatic wait_req(string nm, int max);
      int n = 0;
      while (!irq_req && n < max) begin
         step();
         n++;
      end
      check({nm, "_req_seen"}, 32'(irq_req), 32'd1);
   endtask

   function automatic logic [3:0] low_idx(logic [15:0] v);
      logic [3:0] r = 4'd0;
      for (int k = 15; k >= 0; k--) if (v[k]) r = 4'(k);
      return r;
   endfunction

   initial begin
      int n;
      rst_n = 1'b0; irq_in = '0; mask = '0; ack = 1'b0; ack_id = '0; ovr_clr = 1'b0;
      step(2);
      check("rst_pend_vec", 32'(pend_vec), 32'h0);
      check("rst_irq_req", 32'({irq_req, enc_enable, ack_err}), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      rst_n = 1'b1;
      step(2);

      // Single source, exact latency
      irq_in[5] = 1'b1;
      step(3);
      check("single_pv_early", 32'(pend_vec), 32'h0);
      step();
      check("single_pv_e3", 32'(pend_vec), 32'h0020);
      check("single_req_e3", 32'(irq_req), 32'h0);
      step();
      check("single_req_e4", 32'(irq_req), 32'h1);
      irq_in[5] = 1'b0;
      do_ack(4'd5);
      step(3);
      check("single_pv_clr", 32'(pend_vec), 32'h0);
      check("single_req_low", 32'(irq_req), 32'h0);

      // Multiple sources with mask
      mask = 16'h0008;
      irq_in = 16'h4208;
      wait_req("multi", 20);
      check("multi_pv", 32'(pend_vec), 32'h4200);
      do_ack(4'd9);
      step();
      check("multi_gap", 32'({irq_req, pend_vec}), 32'h0_4000);
      step();
      check("multi_rereq", 32'(irq_req), 32'h1);
      do_ack(4'd14);
      step(3);
      check("multi_pv_masked", 32'({irq_req, pend_vec}), 32'h0_0000);
      mask = 16'h0000;
      wait_req("unmask", 10);
      check("unmask_pv", 32'(pend_vec), 32'h0008);
      do_ack(4'd3);
      irq_in = '0;
      step(4);

      // Bad ack, then acks outside REQ
      irq_in[0] = 1'b1;
      wait_req("bad", 20);
      check("bad_pv", 32'(pend_vec), 32'h0001);
      do_ack(4'd7);
      check("bad_err_pulse", 32'(ack_err), 32'h1);
      step();
      check("bad_err_once", 32'({ack_err, irq_req, pend_vec}), 32'h0_0001);
      step();
      check("bad_rereq", 32'(irq_req), 32'h1);
      do_ack(4'd0);
      do_ack(4'd0);
      check("hold_ack_ignored", 32'(ack_err), 32'h0);
      irq_in = '0;
      step(4);
      mask = 16'hFFFF;
      irq_in[1] = 1'b1;
      step(6);
      do_ack(4'd1);
      check("idle_ack_ignored", 32'({ack_err, irq_req}), 32'h0);
      mask = 16'h0000;
      wait_req("idle_kept", 10);
      check("idle_pend_kept", 32'(pend_vec), 32'h0002);
      do_ack(4'd1);
      irq_in = '0;
      step(4);

      // Overrun, set-wins and ovr_clr
      irq_in[2] = 1'b1; step(2);
      irq_in[2] = 1'b0; step(2);
      irq_in[2] = 1'b1; step(4);
      check("ovr_set", 32'(overrun), 32'h0004);
      wait_req("ovr", 10);
      irq_in[2] = 1'b0; step(3);
      irq_in[2] = 1'b1; step(2);
      do_ack(4'd2);
      step(3);
      check("set_wins", 32'(pend_vec), 32'h0004);
      ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
      check("ovr_clr", 32'(overrun), 32'h0);
      wait_req("after_clr", 10);
      do_ack(4'd2);
      irq_in = '0;
      step(4);

      // Asynchronous reset mid-handshake
      irq_in[4] = 1'b1;
      wait_req("mid", 20);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_outs", 32'({irq_req, enc_enable, ack_err, pend_vec}), 32'h0);
      check("async_rst_ovr", 32'(overrun), 32'h0);
      irq_in = 16'h0001;
      step(2);
      rst_n = 1'b1;
      n = 0;
      while (pend_vec != 16'h0001 && n < 8) begin step(); n++; end
      check("rst_release_edge", 32'(pend_vec), 32'h0001);
      wait_req("post_rst", 10);
      do_ack(4'd0);
      irq_in = '0;
      step(4);

      // Random traffic with an emulated encoder/consumer
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) irq_in = irq_in ^ (16'(1) << $urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) mask = 16'($urandom) & 16'($urandom);
         ovr_clr = ($urandom_range(0, 49) == 0);
         if (m_req && $urandom_range(0, 2) == 0) begin
            ack = 1'b1;
            ack_id = ($urandom_range(0, 7) == 0 || m_pv == 16'h0) ? 4'($urandom) : low_idx(m_pv);
         end else if ($urandom_range(0, 40) == 0) begin
            ack = 1'b1;
            ack_id = 4'($urandom);
         end else begin
            ack = 1'b0;
         end
         step();
      end
      ack = 1'b0; ovr_clr = 1'b0;
      step(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Request-capture stage that sits directly upstream of the 16-input priority encoder. It synchronises 16 asynchronous interrupt lines and detects their rising edges. Each edge is held as a pending bit, and the masked pending vector plus an enable are driven to the encoder. The block then runs a request/acknowledge handshake, and the acknowledged index, taken from the encoder's 4-bit output, clears exactly one pending bit.

## Interface
- `N_SRC`, 16: number of request sources. Fixed at 16 to match the encoder width.
- `SYNC_STAGES`, 2: synchroniser depth on `irq_in`. Legal values are 2 and 3.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: reset, **asynchronous, active-low**.
- `irq_in` input 16: asynchronous request lines. A rising edge raises a request.
- `mask` input 16: synchronous. 1 = source hidden from the encoder. Masking never clears pending.
- `ack` input 1: one-cycle acknowledge pulse from the consumer.
- `ack_id` input 4: index being acknowledged. This is the encoder's binary output.
- `ovr_clr` input 1: synchronous clear of all `overrun` bits.
- `pend_vec` output 16: registered `pending & ~mask`. Feeds the encoder data input.
- `enc_enable` output 1: feeds the encoder enable. High only in state REQ.
- `irq_req` output 1: registered request to the consumer. High only in state REQ.
- `ack_err` output 1: one-cycle pulse when an ack names a bit that is not in `pend_vec`.
- `overrun` output 16: sticky per-source flags. A bit sets when an edge arrives on a source that is already pending.

## Operation
- **Synchroniser.** `irq_in` passes through `SYNC_STAGES` flops, followed by one history flop.
  - `rise[i]` = last sync stage high AND history low.
- **Pending register.**
  - Bit i sets on `rise[i]`.
  - Bit i clears on an accepted ack with `ack_id==i`.
  - If set and clear for the same bit occur in the same cycle, set wins.
- **Overrun.** Bit i sets on `rise[i]` while `pending[i]` is already 1.
  - `ovr_clr` clears all bits. If clear and set coincide, set wins.
- **pend_vec.** Registered each cycle from the current `pending & ~mask`.
- **FSM states.**
  - IDLE: if `pend_vec != 0`, go to REQ.
  - REQ: hold `irq_req=1` and `enc_enable=1` until `ack`. On ack, go to HOLD.
  - HOLD: one cycle with `irq_req=0`, so `pend_vec` and the encoder output can settle. Then go to IDLE unconditionally.
- **Accepted ack.** `ack=1` while in REQ.
  - If `pend_vec[ack_id]==1`: clear `pending[ack_id]`.
  - Otherwise: pulse `ack_err`, clear nothing, still go to HOLD.
  - `ack` in IDLE or HOLD is ignored: no clear, no `ack_err`.
- **Masking while in REQ.** If `pend_vec` becomes 0 while in REQ (all bits masked), the FSM stays in REQ until ack. It does not withdraw the request.
- **Reset values.** All flops are 0, including sync and history. State is IDLE.
  - `pend_vec`, `irq_req`, `enc_enable`, `ack_err` and `overrun` are all 0.
  - A source held high across reset release is seen as a rising edge `SYNC_STAGES` cycles later.
- **Reset asserted mid-handshake.** Clears everything immediately. No ack is required afterwards.

## Timing
Latency below is for `SYNC_STAGES=2`. Edge numbers are `clk` rising edges.
- **Request path.** `irq_in` is stable high before edge 0.
  - `pending` sets at edge 2.
  - `pend_vec` updates at edge 3.
  - FSM enters REQ and `irq_req` rises at edge 4.
- **Ack path.** Ack is sampled at edge a.
  - Pending bit clears and state becomes HOLD at a.
  - `pend_vec` updates and state becomes IDLE at a+1.
  - If bits remain, `irq_req` rises again at a+2.
- **Back-to-back.** Minimum spacing between consecutive `irq_req` assertions is 2 cycles low.
- **ack_err.** High for exactly the cycle after edge a.
- **`mask` change** is visible on `pend_vec` one edge later.
- **`enc_enable`** equals `irq_req`. The encoder output is valid for the whole time `irq_req` is high.

## Test plan
- **Single source.**
  - Stimulus: reset; pulse `irq_in[5]` high (held for at least 3 cycles).
  - Response: `pend_vec=16'h0020` at edge 3, `irq_req=1` at edge 4; ack with `ack_id=5` → `pend_vec=0`, `irq_req` low and stays low.
- **Multiple sources with mask.**
  - Stimulus: edges on bits 3, 9 and 14; `mask=16'h0008`.
  - Response: `pend_vec=16'h4200`; ack 9 → `16'h4000`, `irq_req` re-rises 2 cycles after ack; ack 14 → 0.
  - Then unmask bit 3 → `pend_vec=16'h0008` and a new request.
- **Bad ack.**
  - Stimulus: in REQ with `pend_vec=16'h0001`, ack with `ack_id=7`.
  - Response: `ack_err` pulses once, `pend_vec` unchanged, `irq_req` re-asserts 2 cycles later.
  - Stimulus: ack pulsed in IDLE. Response: no effect.
- **Overrun and set-wins.**
  - Stimulus: a second edge on bit 2 while it is pending.
  - Response: `overrun=16'h0004`.
  - Stimulus: ack of bit 2 in the same cycle as a new `rise[2]`. Response: bit 2 stays pending.
  - Stimulus: `ovr_clr`. Response: `overrun=0`.
- **Reset mid-operation.**
  - Stimulus: assert `rst_n=0` asynchronously while in REQ.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
  - Stimulus: release reset with `irq_in[0]` held high. Response: `pend_vec=16'h0001` 3 edges after release.
